// File: rtl/keycode_pkg.sv
// ----------------------------------------------------------------------------
// keycode_pkg : shared event/state types for the keycode event generator
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package keycode_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'b00,
    EVT_RELEASE = 2'b01,
    EVT_REPEAT  = 2'b10
  } evt_kind_e;

  localparam logic [7:0] KEY_NONE = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2,
    ST_PEND   = 2'd3
  } kg_state_e;

  typedef struct packed {
    evt_kind_e  kind;
    logic [7:0] code;
  } evt_entry_t;

  localparam int EVT_W = $bits(evt_entry_t);

endpackage

`default_nettype wire

// File: rtl/evt_fifo.sv
// ----------------------------------------------------------------------------
// evt_fifo : synchronous show-ahead FIFO with occupancy and push-drop flag
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop_req,
  output logic                     valid,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign valid   = (count != '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop_req && valid;
  // A pop frees the slot this edge, so a push into a full FIFO is still taken.
  assign do_push = push && (!full || do_pop);
  assign dropped = push && !do_push;
  assign head    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/keycode_event_gen.sv
// ----------------------------------------------------------------------------
// keycode_event_gen : glitch-filtered keycode to PRESS/RELEASE/REPEAT events
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module keycode_event_gen
  import keycode_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_RATE   = 5000000,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic [7:0]                    keycode_in,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [7:0]                    evt_code,
  output logic [1:0]                    evt_kind,
  output logic [7:0]                    held_code,
  output logic                          held_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clr_overflow
);

  localparam int SCW  = $clog2(STABLE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW   = (RMAX < 2) ? 1 : $clog2(RMAX);

  localparam logic [SCW-1:0] STABLE_LAST = SCW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]  DELAY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0]  RATE_LAST   = CW'(REPEAT_RATE - 1);

  logic [7:0]     sync1;
  logic [7:0]     sync2;
  logic [7:0]     cand;
  logic [SCW-1:0] stab_cnt;
  logic           change;

  kg_state_e      state;
  kg_state_e      state_n;
  logic [CW-1:0]  rpt_cnt;
  logic [CW-1:0]  rpt_cnt_n;
  logic           push;
  evt_entry_t     push_entry;
  evt_entry_t     head_entry;
  logic           fifo_dropped;

  assign change     = (stab_cnt == STABLE_LAST) && (cand != held_code);
  assign held_valid = (held_code != KEY_NONE);

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sync1     <= KEY_NONE;
      sync2     <= KEY_NONE;
      cand      <= KEY_NONE;
      stab_cnt  <= '0;
      held_code <= KEY_NONE;
    end else begin
      sync1 <= keycode_in;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand     <= sync2;
        stab_cnt <= '0;
      end else if (stab_cnt != STABLE_LAST) begin
        stab_cnt <= stab_cnt + SCW'(1);
      end
      if (change) begin
        held_code <= cand;
      end
    end
  end

  // held_code still carries the old key on a change cycle, so it names the RELEASE.
  always_comb begin
    state_n         = state;
    rpt_cnt_n       = rpt_cnt;
    push            = 1'b0;
    push_entry.kind = EVT_PRESS;
    push_entry.code = KEY_NONE;
    case (state)
      ST_IDLE: begin
        if (change) begin
          push            = 1'b1;
          push_entry.kind = EVT_PRESS;
          push_entry.code = cand;
          rpt_cnt_n       = '0;
          state_n         = ST_DELAY;
        end
      end
      ST_DELAY, ST_REPEAT: begin
        if (change) begin
          push            = 1'b1;
          push_entry.kind = EVT_RELEASE;
          push_entry.code = held_code;
          state_n         = (cand == KEY_NONE) ? ST_IDLE : ST_PEND;
        end else if (rpt_cnt == ((state == ST_DELAY) ? DELAY_LAST : RATE_LAST)) begin
          push            = 1'b1;
          push_entry.kind = EVT_REPEAT;
          push_entry.code = held_code;
          rpt_cnt_n       = '0;
          state_n         = ST_REPEAT;
        end else begin
          rpt_cnt_n = rpt_cnt + CW'(1);
        end
      end
      ST_PEND: begin
        push            = 1'b1;
        push_entry.kind = EVT_PRESS;
        push_entry.code = held_code;
        rpt_cnt_n       = '0;
        state_n         = ST_DELAY;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state    <= ST_IDLE;
      rpt_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      state   <= state_n;
      rpt_cnt <= rpt_cnt_n;
      // Set beats clear; lost REPEATs are not worth flagging.
      if (fifo_dropped && (push_entry.kind != EVT_REPEAT)) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .push      (push),
    .push_data (push_entry),
    .pop_req   (evt_ready),
    .valid     (evt_valid),
    .head      (head_entry),
    .count     (fifo_count),
    .dropped   (fifo_dropped)
  );

  assign evt_code = head_entry.code;
  assign evt_kind = head_entry.kind;

endmodule

`default_nettype wire

// File: tb/tb_keycode_event_gen.sv
// ----------------------------------------------------------------------------
// tb_keycode_event_gen : directed self-checking bench for keycode_event_gen
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_keycode_event_gen;
  import keycode_pkg::*;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n;
  logic [7:0] keycode_in;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic [1:0] evt_kind;
  logic [7:0] held_code;
  logic       held_valid;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       clr_overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int tt       = 0;

  typedef struct {
    int         t;
    logic [1:0] k;
    logic [7:0] c;
  } exp_ev_t;

  typedef struct {
    int         t;
    logic [7:0] c;
  } key_chg_t;

  exp_ev_t  evq[$];
  key_chg_t kq[$];

  keycode_event_gen #(
    .STABLE_CYCLES (4),
    .REPEAT_DELAY  (20),
    .REPEAT_RATE   (5),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .keycode_in    (keycode_in),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_code      (evt_code),
    .evt_kind      (evt_kind),
    .held_code     (held_code),
    .held_valid    (held_valid),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .clr_overflow  (clr_overflow)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, tt);
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
    tt++;
  endtask

  task automatic adv_to(input int target);
    while (tt < target) tick();
  endtask

  task automatic add_ev(input int t, input logic [1:0] k, input logic [7:0] c);
    exp_ev_t e;
    e.t = t; e.k = k; e.c = c;
    evq.push_back(e);
  endtask

  task automatic add_key(input int t, input logic [7:0] c);
    key_chg_t k;
    k.t = t; k.c = c;
    kq.push_back(k);
  endtask

  // With evt_ready high each event is visible for exactly one cycle after its push.
  task automatic run_window(input string tag, input int n);
    logic       exp_v;
    logic [1:0] exp_k;
    logic [7:0] exp_c;
    for (int t = 1; t <= n; t++) begin
      tick();
      exp_v = 1'b0; exp_k = 2'b00; exp_c = 8'h00;
      foreach (evq[i]) begin
        if (evq[i].t == t) begin
          exp_v = 1'b1; exp_k = evq[i].k; exp_c = evq[i].c;
        end
      end
      check({tag, "_valid"}, 32'(evt_valid), 32'(exp_v));
      if (exp_v) begin
        check({tag, "_kind"}, 32'(evt_kind), 32'(exp_k));
        check({tag, "_code"}, 32'(evt_code), 32'(exp_c));
      end
      foreach (kq[i]) begin
        if (kq[i].t == t) keycode_in = kq[i].c;
      end
    end
    evq.delete();
    kq.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},  32'(evt_valid),  32'd0);
    check({tag, "_count"},  32'(fifo_count), 32'd0);
    check({tag, "_held"},   32'(held_code),  32'd0);
    check({tag, "_heldv"},  32'(held_valid), 32'd0);
    check({tag, "_ovf"},    32'(overflow),   32'd0);
    check({tag, "_code"},   32'(evt_code),   32'd0);
    check({tag, "_kind"},   32'(evt_kind),   32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_reset_n = 1'b0;
    keycode_in    = 8'h00;
    evt_ready     = 1'b0;
    clr_overflow  = 1'b0;
    repeat (3) tick();
    reset_reset_n = 1'b1;
    tick();
    check_all_zero("reset");

    // Test 1: press, typematic repeat, release.
    evt_ready  = 1'b1;
    keycode_in = 8'h04;
    add_ev(7, EVT_PRESS, 8'h04);
    for (int t = 27; t <= 62; t += 5) add_ev(t, EVT_REPEAT, 8'h04);
    add_ev(67, EVT_RELEASE, 8'h04);
    add_key(60, 8'h00);
    run_window("t1", 70);
    check("t1_heldv_end", 32'(held_valid), 32'd0);

    // Test 2: 3-cycle glitch is filtered out.
    keycode_in = 8'h1A;
    repeat (3) tick();
    keycode_in = 8'h00;
    repeat (10) tick();
    check("t2_count", 32'(fifo_count), 32'd0);
    check("t2_held",  32'(held_code),  32'd0);
    check("t2_valid", 32'(evt_valid),  32'd0);

    // Test 3: direct K->J switch restarts the repeat timer from PRESS J.
    keycode_in = 8'h04;
    add_ev(7,  EVT_PRESS,   8'h04);
    add_ev(17, EVT_RELEASE, 8'h04);
    add_ev(18, EVT_PRESS,   8'h07);
    add_ev(38, EVT_REPEAT,  8'h07);
    add_ev(43, EVT_REPEAT,  8'h07);
    add_ev(48, EVT_REPEAT,  8'h07);
    add_ev(52, EVT_RELEASE, 8'h07);
    add_key(10, 8'h07);
    add_key(45, 8'h00);
    run_window("t3", 56);

    // Test 4: fill the FIFO, lose the 5th event, clear, then lose a REPEAT.
    evt_ready  = 1'b0;
    tt         = 0;
    keycode_in = 8'h04;
    adv_to(8);   check("t4_cnt1", 32'(fifo_count), 32'd1); keycode_in = 8'h00;
    adv_to(16);  check("t4_cnt2", 32'(fifo_count), 32'd2); keycode_in = 8'h04;
    adv_to(24);  check("t4_cnt3", 32'(fifo_count), 32'd3); keycode_in = 8'h00;
    adv_to(32);
    check("t4_cnt4", 32'(fifo_count), 32'd4);
    check("t4_ovf_pre", 32'(overflow), 32'd0);
    check("t4_head_kind", 32'(evt_kind), 32'(EVT_PRESS));
    keycode_in = 8'h04;
    adv_to(40);
    check("t4_cnt_sat", 32'(fifo_count), 32'd4);
    check("t4_ovf_set", 32'(overflow), 32'd1);
    check("t4_held", 32'(held_code), 32'h04);
    check("t4_heldv", 32'(held_valid), 32'd1);
    clr_overflow = 1'b1;
    adv_to(41);
    clr_overflow = 1'b0;
    check("t4_ovf_clr", 32'(overflow), 32'd0);
    adv_to(60);
    check("t4_ovf_rpt", 32'(overflow), 32'd0);
    check("t4_cnt_rpt", 32'(fifo_count), 32'd4);

    // Test 5: push into a full FIFO with a simultaneous pop.
    keycode_in = 8'h00;
    adv_to(65);  evt_ready = 1'b1;
    adv_to(66);  evt_ready = 1'b0;
    check("t5_cnt_pop", 32'(fifo_count), 32'd3);
    check("t5_head_rel", 32'(evt_kind), 32'(EVT_RELEASE));
    adv_to(68);
    check("t5_cnt_refill", 32'(fifo_count), 32'd4);
    check("t5_ovf_refill", 32'(overflow), 32'd0);
    adv_to(70);  keycode_in = 8'h07;
    adv_to(76);  evt_ready = 1'b1;
    check("t5_pre_cnt", 32'(fifo_count), 32'd4);
    adv_to(77);
    check("t5_cnt_same", 32'(fifo_count), 32'd4);
    check("t5_ovf_same", 32'(overflow), 32'd0);
    check("t5_h0_kind", 32'(evt_kind), 32'(EVT_PRESS));
    check("t5_h0_code", 32'(evt_code), 32'h04);
    adv_to(78);
    check("t5_h1_kind", 32'(evt_kind), 32'(EVT_RELEASE));
    check("t5_h1_code", 32'(evt_code), 32'h04);
    adv_to(79);
    check("t5_h2_kind", 32'(evt_kind), 32'(EVT_RELEASE));
    check("t5_h2_code", 32'(evt_code), 32'h04);
    adv_to(80);
    check("t5_h3_kind", 32'(evt_kind), 32'(EVT_PRESS));
    check("t5_h3_code", 32'(evt_code), 32'h07);
    adv_to(81);
    check("t5_drained", 32'(fifo_count), 32'd0);
    check("t5_valid0", 32'(evt_valid), 32'd0);

    // Test 6: one-cycle reset while auto-repeating.
    adv_to(100);
    reset_reset_n = 1'b0;
    adv_to(101);
    reset_reset_n = 1'b1;
    check_all_zero("t6_rst");
    adv_to(107);
    check("t6_valid_early", 32'(evt_valid), 32'd0);
    adv_to(108);
    check("t6_valid", 32'(evt_valid), 32'd1);
    check("t6_kind", 32'(evt_kind), 32'(EVT_PRESS));
    check("t6_code", 32'(evt_code), 32'h07);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
